pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter MC_CYCLES, default 8, meaning total stall cycles for one multi-cycle EXE op (legal 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have ports id_rs_addr and id_rt_addr, input, 5 bits each: source registers of the instruction in ID.
REQ-005 The block SHALL have ports id_rs_used and id_rt_used, input, 1 bit each: the ID instruction reads that source.
REQ-006 The block SHALL have port exe_reg_write_addr, input, 5 bits: destination of the instruction in EXE (ID_EXE output).
REQ-007 The block SHALL have ports exe_RegWE and exe_is_load, input, 1 bit each: the EXE instruction writes a register / is a memory load.
REQ-008 The block SHALL have port mc_start, input, 1 bit: a multi-cycle op is in EXE this cycle (one-cycle pulse).
REQ-009 The block SHALL have port branch_taken, input, 1 bit: the branch resolved in ID redirects the PC.
REQ-010 The block SHALL have ports pc_we and if_id_we, output, 1 bit each: PC / IF_ID write enables.
REQ-011 The block SHALL have port if_id_flush, output, 1 bit: IF_ID loads a bubble.
REQ-012 The block SHALL have port id_exe_pause, output, 1 bit: ID_EXE loads its default bubble (drives ID_EXE pause).
REQ-013 The block SHALL have port exe_hold, output, 1 bit: EXE-stage and ID_EXE contents frozen.
REQ-014 The block SHALL have ports busy (1 bit) and stall_cycles (16 bits), output: in MC_WAIT; saturating count of cycles with pc_we=0.

Function
REQ-015 The block SHALL implement states RUN and MC_WAIT plus a 4-bit down counter cnt.
REQ-016 The block SHALL detect load-use hazard lu = exe_is_load & exe_RegWE & exe_reg_write_addr!=0 & ((id_rs_used & id_rs_addr==exe_reg_write_addr) | (id_rt_used & id_rt_addr==exe_reg_write_addr)), combinationally.
REQ-017 In RUN with mc_start=1, outputs SHALL be pc_we=0, if_id_we=0, exe_hold=1, id_exe_pause=0, if_id_flush=0 that cycle; next state MC_WAIT, cnt<=MC_CYCLES-2.
REQ-018 In MC_WAIT, outputs SHALL be pc_we=0, if_id_we=0, exe_hold=1, busy=1, id_exe_pause=0, if_id_flush=0; cnt decrements each cycle; when cnt==0, next state RUN.
REQ-019 Total front-end stall for one mc_start SHALL be exactly MC_CYCLES cycles, including the mc_start cycle.
REQ-020 In RUN with mc_start=0 and lu=1, outputs SHALL be pc_we=0, if_id_we=0, id_exe_pause=1, exe_hold=0, if_id_flush=0 for that cycle only; state stays RUN.
REQ-021 In RUN with mc_start=0, lu=0, branch_taken=1, outputs SHALL be pc_we=1, if_id_we=1, if_id_flush=1, id_exe_pause=0.
REQ-022 In RUN with no event, outputs SHALL be pc_we=1, if_id_we=1, all others 0.
REQ-023 Priority SHALL be MC_WAIT state > mc_start > lu > branch_taken; lower-priority inputs are ignored, not queued.
REQ-024 mc_start, lu and branch_taken in MC_WAIT SHALL be ignored.
REQ-025 stall_cycles SHALL increment on each rising edge where pc_we=0, saturating at 16'hFFFF.

Reset
REQ-026 While rst=1, state SHALL be RUN, cnt=0, stall_cycles=0, independent of clk.
REQ-027 With rst=1, outputs SHALL be busy=0, exe_hold=0, pc_we=0, if_id_we=0, id_exe_pause=1, if_id_flush=1 (all outputs except stall_cycles are combinational and forced).
REQ-028 rst asserted mid-MC_WAIT SHALL abort the op; first cycle after release is RUN with no stall.

Verification
REQ-029 Load r5 in EXE (exe_is_load=1, exe_RegWE=1, addr=5), ID rs=5 used -> one cycle pc_we=0, id_exe_pause=1; next cycle (no load) pc_we=1; stall_cycles=1.
REQ-030 Same with addr=0 or id_rs_used=0 -> no stall.
REQ-031 mc_start pulse, MC_CYCLES=8 -> pc_we=0 and exe_hold=1 exactly 8 cycles, busy=1 for cycles 2..8, stall_cycles=8.
REQ-032 mc_start, lu and branch_taken together -> mc stall only, if_id_flush=0, id_exe_pause=0.
REQ-033 lu=1 with branch_taken=1 -> pause, no flush; branch_taken alone -> if_id_flush=1, pc_we=1.
REQ-034 rst pulsed in 3rd MC_WAIT cycle -> busy=0 immediately; after release, pc_we=1, stall_cycles=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Front-end stall / flush controller for a five-stage pipeline. It arbitrates
// three events: a multi-cycle EXE operation, a load-use hazard between EXE and
// ID, and a taken branch resolved in ID. A multi-cycle op freezes the front
// end and the EXE stage for MC_CYCLES cycles in total. A load-use hazard
// inserts one bubble into ID_EXE. A taken branch squashes the IF_ID entry.
//
// State table
//   state   | meaning
//   --------+----------------------------------------------------------------
//   RUN     | normal issue; events are arbitrated mc_start > lu > branch_taken
//   MC_WAIT | multi-cycle op in flight; front end and EXE frozen, inputs ignored
//
// Parameters
//   MC_CYCLES          total stall cycles for one multi-cycle op (2..16)
//
// Ports
//   clk                clock, rising edge
//   rst                asynchronous active-high reset
//   id_rs_addr         rs source register of the ID instruction
//   id_rt_addr         rt source register of the ID instruction
//   id_rs_used         ID instruction reads rs
//   id_rt_used         ID instruction reads rt
//   exe_reg_write_addr destination register of the EXE instruction
//   exe_RegWE          EXE instruction writes a register
//   exe_is_load        EXE instruction is a memory load
//   mc_start           one-cycle pulse: multi-cycle op is in EXE
//   branch_taken       branch resolved in ID redirects the PC
//   pc_we              PC write enable
//   if_id_we           IF_ID write enable
//   if_id_flush        IF_ID loads a bubble
//   id_exe_pause       ID_EXE loads its default bubble
//   exe_hold           EXE stage and ID_EXE contents frozen
//   busy               controller is in MC_WAIT
//   stall_cycles       saturating count of clock edges with pc_we low
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int MC_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [4:0]  exe_reg_write_addr,
    input  logic        exe_RegWE,
    input  logic        exe_is_load,
    input  logic        mc_start,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_exe_pause,
    output logic        exe_hold,
    output logic        busy,
    output logic [15:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    // The mc_start cycle is one stall cycle and MC_WAIT lasts cnt_load+1
    // cycles, so loading MC_CYCLES-2 gives exactly MC_CYCLES stalled cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MC_CYCLES - 2);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       lu;
    logic       rs_hit;
    logic       rt_hit;

    // Load-use hazard: a load in EXE writing a non-zero register that the ID
    // instruction actually reads. r0 is hard-wired zero and never hazards.
    assign rs_hit = id_rs_used && (id_rs_addr == exe_reg_write_addr);
    assign rt_hit = id_rt_used && (id_rt_addr == exe_reg_write_addr);
    assign lu     = exe_is_load && exe_RegWE && (exe_reg_write_addr != 5'd0)
                    && (rs_hit || rt_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_pause = 1'b0;
        exe_hold     = 1'b0;
        busy         = 1'b0;

        if (rst) begin
            // Outputs are forced while reset is held, independent of state.
            state_nxt    = RUN;
            cnt_nxt      = 4'd0;
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_exe_pause = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (mc_start) begin
                        pc_we     = 1'b0;
                        if_id_we  = 1'b0;
                        exe_hold  = 1'b1;
                        state_nxt = MC_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else if (lu) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_exe_pause = 1'b1;
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                    exe_hold = 1'b1;
                    busy     = 1'b1;
                    if (cnt == 4'd0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (!pc_we && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [4:0]  exe_reg_write_addr;
    logic        exe_RegWE;
    logic        exe_is_load;
    logic        mc_start;
    logic        branch_taken;
    logic        pc_we;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_exe_pause;
    logic        exe_hold;
    logic        busy;
    logic [15:0] stall_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    pipeline_ctrl #(.MC_CYCLES(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs_addr         (id_rs_addr),
        .id_rt_addr         (id_rt_addr),
        .id_rs_used         (id_rs_used),
        .id_rt_used         (id_rt_used),
        .exe_reg_write_addr (exe_reg_write_addr),
        .exe_RegWE          (exe_RegWE),
        .exe_is_load        (exe_is_load),
        .mc_start           (mc_start),
        .branch_taken       (branch_taken),
        .pc_we              (pc_we),
        .if_id_we           (if_id_we),
        .if_id_flush        (if_id_flush),
        .id_exe_pause       (id_exe_pause),
        .exe_hold           (exe_hold),
        .busy               (busy),
        .stall_cycles       (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the six combinational outputs as one packed vector:
    // {busy, exe_hold, pc_we, if_id_we, id_exe_pause, if_id_flush}
    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {10'd0, busy, exe_hold, pc_we, if_id_we, id_exe_pause, if_id_flush},
            {10'd0, exp});
    endtask

    task automatic drive(input logic ld, input logic we, input logic [4:0] waddr,
                         input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu,
                         input logic mc, input logic br);
        exe_is_load        = ld;
        exe_RegWE          = we;
        exe_reg_write_addr = waddr;
        id_rs_addr         = rs;
        id_rs_used         = rsu;
        id_rt_addr         = rt;
        id_rt_used         = rtu;
        mc_start           = mc;
        branch_taken       = br;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output patterns {busy, exe_hold, pc_we, if_id_we, id_exe_pause, if_id_flush}
    localparam logic [5:0] O_RUN   = 6'b001100;
    localparam logic [5:0] O_LU    = 6'b000010;
    localparam logic [5:0] O_BR    = 6'b001101;
    localparam logic [5:0] O_MC1   = 6'b010000;
    localparam logic [5:0] O_MCW   = 6'b110000;
    localparam logic [5:0] O_RST   = 6'b000011;

    initial begin
        rst = 1'b1;
        idle();
        chk_out("reset_outputs", O_RST);
        chk("reset_stall", stall_cycles, 16'd0);
        // Clock edges during reset must not count stalls.
        tick();
        tick();
        chk("reset_stall_clocked", stall_cycles, 16'd0);
        chk_out("reset_outputs_clocked", O_RST);

        #2;
        rst = 1'b0;
        idle();
        chk_out("idle_run", O_RUN);
        tick();
        chk("idle_stall", stall_cycles, 16'd0);

        // Load r5, ID reads r5 via rs: one bubble.
        drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("lu_rs", O_LU);
        tick();
        chk("lu_rs_stall", stall_cycles, 16'd1);
        idle();
        chk_out("lu_release", O_RUN);
        tick();
        chk("lu_release_stall", stall_cycles, 16'd1);

        // Destination r0 never hazards.
        drive(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk_out("lu_r0", O_RUN);
        tick();
        // Matching address but rs not used.
        drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        chk_out("lu_rs_unused", O_RUN);
        tick();
        // Not a load.
        drive(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("lu_not_load", O_RUN);
        tick();
        // Load without register write.
        drive(1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("lu_no_regwe", O_RUN);
        tick();
        chk("no_stall_cases", stall_cycles, 16'd1);

        // Hazard through rt.
        drive(1'b1, 1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        chk_out("lu_rt", O_LU);
        tick();
        chk("lu_rt_stall", stall_cycles, 16'd2);

        // Branch alone flushes, PC still advances.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_out("branch_only", O_BR);
        tick();
        chk("branch_stall", stall_cycles, 16'd2);

        // Load-use beats branch: pause, no flush.
        drive(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_out("lu_over_branch", O_LU);
        tick();
        chk("lu_over_branch_stall", stall_cycles, 16'd3);

        // mc_start with lu and branch: mc stall only, 8 stalled cycles total.
        drive(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_out("mc_cycle1", O_MC1);
        tick();
        for (int i = 2; i <= 8; i++) begin
            // Events during MC_WAIT must be ignored.
            if (i % 2 == 0)
                drive(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
            else
                idle();
            chk_out($sformatf("mc_cycle%0d", i), O_MCW);
            tick();
        end
        idle();
        chk_out("mc_done", O_RUN);
        chk("mc_stall_count", stall_cycles, 16'd11);
        tick();
        chk("mc_done_stall", stall_cycles, 16'd11);

        // Reset aborts an op in the 3rd MC_WAIT cycle.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_out("mc2_cycle1", O_MC1);
        tick();
        idle();
        chk_out("mc2_wait1", O_MCW);
        tick();
        chk_out("mc2_wait2", O_MCW);
        tick();
        chk_out("mc2_wait3", O_MCW);
        rst = 1'b1;
        #1;
        chk_out("mid_mc_reset_outputs", O_RST);
        chk("mid_mc_reset_stall", stall_cycles, 16'd0);
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk_out("post_reset_run", O_RUN);
        tick();
        chk_out("post_reset_run2", O_RUN);
        chk("post_reset_stall", stall_cycles, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
